// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arbiter
//  Purpose  : Two-port arbiter and sequencer for the single-ported SoC
//             memory. Port 0 is instruction fetch (read only) and port 1 is
//             load/store. Each access runs ISSUE -> WAIT (LAT cycles) -> RESP.
//             When both ports contend, grants alternate (round robin).
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    AW   address width
//    DW   data width
//    LAT  memory read latency in cycles, 1..4
//  Ports
//    clk, rst                       clock, asynchronous active-high reset
//    p0_req/addr/word               fetch request and its fields
//    p0_ready/rdata                 fetch completion pulse, last fetch data
//    p1_req/we/addr/word/wdata      load/store request and its fields
//    p1_ready/rdata                 load/store completion pulse, last load data
//    mem_en/we/addr/word/wdata      memory command
//    mem_rdata                      memory read data
//    busy                           sequencer is not idle
// ============================================================================
module mem_arbiter #(
   parameter int AW  = 10,
   parameter int DW  = 64,
   parameter int LAT = 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          p0_req,
   input  logic [AW-1:0] p0_addr,
   input  logic [1:0]    p0_word,
   output logic          p0_ready,
   output logic [DW-1:0] p0_rdata,
   input  logic          p1_req,
   input  logic          p1_we,
   input  logic [AW-1:0] p1_addr,
   input  logic [1:0]    p1_word,
   input  logic [DW-1:0] p1_wdata,
   output logic          p1_ready,
   output logic [DW-1:0] p1_rdata,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [1:0]    mem_word,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   output logic          busy
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_RESP  = 2'd3
   } state_t;

   // Wait counter runs 0..LAT-1; two bits cover the legal LAT range.
   localparam logic [1:0] LAST_WAIT = 2'(LAT - 1);

   state_t          state_q,      state_d;
   logic [1:0]      wcnt_q,       wcnt_d;
   logic            gnt_q,        gnt_d;
   logic            last_grant_q, last_grant_d;
   logic [AW-1:0]   addr_q,       addr_d;
   logic [1:0]      word_q,       word_d;
   logic            we_q,         we_d;
   logic [DW-1:0]   wdata_q,      wdata_d;
   logic [DW-1:0]   p0_rdata_q,   p0_rdata_d;
   logic [DW-1:0]   p1_rdata_q,   p1_rdata_d;
   logic            gnt_w;

   // Grant selection: a lone requester wins; on contention the port that
   // did not win last time wins.
   always_comb begin
      if (p0_req && p1_req) begin
         gnt_w = ~last_grant_q;
      end else begin
         gnt_w = p1_req;
      end
   end

   always_comb begin
      state_d      = state_q;
      wcnt_d       = wcnt_q;
      gnt_d        = gnt_q;
      last_grant_d = last_grant_q;
      addr_d       = addr_q;
      word_d       = word_q;
      we_d         = we_q;
      wdata_d      = wdata_q;
      p0_rdata_d   = p0_rdata_q;
      p1_rdata_d   = p1_rdata_q;

      case (state_q)
         S_IDLE: begin
            if (p0_req || p1_req) begin
               state_d      = S_ISSUE;
               gnt_d        = gnt_w;
               last_grant_d = gnt_w;
               if (gnt_w) begin
                  addr_d  = p1_addr;
                  word_d  = p1_word;
                  we_d    = p1_we;
                  wdata_d = p1_wdata;
               end else begin
                  // Fetch port is read only and carries no write data.
                  addr_d  = p0_addr;
                  word_d  = p0_word;
                  we_d    = 1'b0;
                  wdata_d = '0;
               end
            end
         end
         S_ISSUE: begin
            state_d = S_WAIT;
            wcnt_d  = 2'd0;
         end
         S_WAIT: begin
            if (wcnt_q == LAST_WAIT) begin
               state_d = S_RESP;
               // Read data is valid at the edge ending the last WAIT cycle.
               if (!we_q) begin
                  if (gnt_q) begin
                     p1_rdata_d = mem_rdata;
                  end else begin
                     p0_rdata_d = mem_rdata;
                  end
               end
            end else begin
               wcnt_d = wcnt_q + 2'd1;
            end
         end
         S_RESP: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         wcnt_q       <= 2'd0;
         gnt_q        <= 1'b0;
         // Port 0 wins the first contention after reset.
         last_grant_q <= 1'b1;
         addr_q       <= '0;
         word_q       <= 2'd0;
         we_q         <= 1'b0;
         wdata_q      <= '0;
         p0_rdata_q   <= '0;
         p1_rdata_q   <= '0;
      end else begin
         state_q      <= state_d;
         wcnt_q       <= wcnt_d;
         gnt_q        <= gnt_d;
         last_grant_q <= last_grant_d;
         addr_q       <= addr_d;
         word_q       <= word_d;
         we_q         <= we_d;
         wdata_q      <= wdata_d;
         p0_rdata_q   <= p0_rdata_d;
         p1_rdata_q   <= p1_rdata_d;
      end
   end

   assign mem_en    = (state_q == S_ISSUE);
   assign mem_we    = (state_q == S_ISSUE) && we_q;
   assign mem_addr  = addr_q;
   assign mem_word  = word_q;
   assign mem_wdata = wdata_q;
   assign p0_ready  = (state_q == S_RESP) && !gnt_q;
   assign p1_ready  = (state_q == S_RESP) &&  gnt_q;
   assign p0_rdata  = p0_rdata_q;
   assign p1_rdata  = p1_rdata_q;
   assign busy      = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_arbiter
//  Purpose  : Directed self-checking bench for mem_arbiter. Instance A is
//             built with LAT=1, instance B with LAT=3; each has its own
//             memory model that only presents valid read data in the last
//             WAIT cycle.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_arbiter;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // ---------------- instance A (LAT=1) signals ----------------
   logic        a_p0_req, a_p0_ready, a_p1_req, a_p1_we, a_p1_ready;
   logic [9:0]  a_p0_addr, a_p1_addr, a_mem_addr;
   logic [1:0]  a_p0_word, a_p1_word, a_mem_word;
   logic [63:0] a_p0_rdata, a_p1_rdata, a_p1_wdata, a_mem_wdata, a_mem_rdata;
   logic        a_mem_en, a_mem_we, a_busy;

   // ---------------- instance B (LAT=3) signals ----------------
   logic        b_p0_req, b_p0_ready, b_p1_req, b_p1_we, b_p1_ready;
   logic [9:0]  b_p0_addr, b_p1_addr, b_mem_addr;
   logic [1:0]  b_p0_word, b_p1_word, b_mem_word;
   logic [63:0] b_p0_rdata, b_p1_rdata, b_p1_wdata, b_mem_wdata, b_mem_rdata;
   logic        b_mem_en, b_mem_we, b_busy;

   mem_arbiter #(.AW(10), .DW(64), .LAT(1)) u_dut_a (
      .clk(clk), .rst(rst),
      .p0_req(a_p0_req), .p0_addr(a_p0_addr), .p0_word(a_p0_word),
      .p0_ready(a_p0_ready), .p0_rdata(a_p0_rdata),
      .p1_req(a_p1_req), .p1_we(a_p1_we), .p1_addr(a_p1_addr),
      .p1_word(a_p1_word), .p1_wdata(a_p1_wdata),
      .p1_ready(a_p1_ready), .p1_rdata(a_p1_rdata),
      .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr),
      .mem_word(a_mem_word), .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata),
      .busy(a_busy)
   );

   mem_arbiter #(.AW(10), .DW(64), .LAT(3)) u_dut_b (
      .clk(clk), .rst(rst),
      .p0_req(b_p0_req), .p0_addr(b_p0_addr), .p0_word(b_p0_word),
      .p0_ready(b_p0_ready), .p0_rdata(b_p0_rdata),
      .p1_req(b_p1_req), .p1_we(b_p1_we), .p1_addr(b_p1_addr),
      .p1_word(b_p1_word), .p1_wdata(b_p1_wdata),
      .p1_ready(b_p1_ready), .p1_rdata(b_p1_rdata),
      .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
      .mem_word(b_mem_word), .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata),
      .busy(b_busy)
   );

   // Preloaded memory contents.
   function automatic logic [63:0] base_data(input logic [9:0] a);
      case (a)
         10'h004: base_data = 64'h1122_3344_5566_7788;
         10'h020: base_data = 64'hCAFE_F00D_1234_5678;
         10'h030: base_data = 64'hA5A5_0030_0000_0001;
         10'h040: base_data = 64'h5A5A_0040_0000_0002;
         10'h055: base_data = 64'h0123_4567_89AB_CDEF;
         default: base_data = {54'h3F_0000_0000_0000, a};
      endcase
   endfunction

   localparam logic [63:0] GARBAGE = 64'hBADD_0000_0000_BADD;

   // Memory model A: one remembered store, read data valid only LAT cycles
   // after the ISSUE cycle.
   logic        a_st_valid = 1'b0;
   logic [9:0]  a_st_addr  = '0;
   logic [63:0] a_st_data  = '0;
   int          a_cnt      = 0;
   always @(posedge clk) begin
      if (a_mem_en && a_mem_we) begin
         a_st_valid <= 1'b1;
         a_st_addr  <= a_mem_addr;
         a_st_data  <= a_mem_wdata;
      end
   end
   always @(posedge clk or posedge rst) begin
      if (rst)                         a_cnt <= 0;
      else if (a_mem_en)               a_cnt <= 1;
      else if (a_cnt != 0 && a_cnt < 8) a_cnt <= a_cnt + 1;
   end
   assign a_mem_rdata = (a_cnt != 1) ? GARBAGE :
                        (a_st_valid && a_st_addr == a_mem_addr) ? a_st_data :
                        base_data(a_mem_addr);

   // Memory model B: read only, LAT=3.
   int b_cnt = 0;
   always @(posedge clk or posedge rst) begin
      if (rst)                         b_cnt <= 0;
      else if (b_mem_en)               b_cnt <= 1;
      else if (b_cnt != 0 && b_cnt < 8) b_cnt <= b_cnt + 1;
   end
   assign b_mem_rdata = (b_cnt == 3) ? base_data(b_mem_addr) : GARBAGE;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int seen;
      rst = 1'b1;
      a_p0_req = 0; a_p0_addr = '0; a_p0_word = '0;
      a_p1_req = 0; a_p1_we = 0; a_p1_addr = '0; a_p1_word = '0; a_p1_wdata = '0;
      b_p0_req = 0; b_p0_addr = '0; b_p0_word = '0;
      b_p1_req = 0; b_p1_we = 0; b_p1_addr = '0; b_p1_word = '0; b_p1_wdata = '0;
      tick();
      tick();
      check("rst_en",    a_mem_en, 0);
      check("rst_busy",  a_busy, 0);
      check("rst_rdy",   {a_p1_ready, a_p0_ready}, 0);
      check("rst_p0rd",  a_p0_rdata, 0);
      check("rst_addr",  a_mem_addr, 0);
      rst = 1'b0;

      // Idle after reset: no memory strobes.
      seen = 0;
      repeat (20) begin
         tick();
         seen += int'(a_mem_en);
      end
      check("idle_no_en", seen, 0);

      // Single fetch, LAT=1.
      a_p0_req = 1; a_p0_addr = 10'h004; a_p0_word = 2'd3;
      check("f_c_busy", a_busy, 0);
      tick();
      check("f_c1_en",   a_mem_en, 1);
      check("f_c1_addr", a_mem_addr, 10'h004);
      check("f_c1_we",   a_mem_we, 0);
      check("f_c1_word", a_mem_word, 2'd3);
      tick();
      check("f_c2_en",   a_mem_en, 0);
      check("f_c2_busy", a_busy, 1);
      tick();
      check("f_c3_rdy",  a_p0_ready, 1);
      check("f_c3_p1r",  a_p1_ready, 0);
      check("f_c3_data", a_p0_rdata, 64'h1122_3344_5566_7788);
      a_p0_req = 0;
      tick();
      check("f_c4_rdy",  a_p0_ready, 0);
      check("f_c4_busy", a_busy, 0);

      // Request dropped and fields changed mid-transaction.
      a_p0_req = 1; a_p0_addr = 10'h030;
      tick();
      a_p0_req = 0; a_p0_addr = 10'h3FF;
      check("drop_addr", a_mem_addr, 10'h030);
      tick();
      tick();
      check("drop_rdy",  a_p0_ready, 1);
      check("drop_data", a_p0_rdata, 64'hA5A5_0030_0000_0001);
      tick();

      // Load on port 1.
      a_p1_req = 1; a_p1_we = 0; a_p1_addr = 10'h020; a_p1_word = 2'd3;
      tick();
      tick();
      tick();
      check("ld_rdy",  {a_p1_ready, a_p0_ready}, 2'b10);
      check("ld_data", a_p1_rdata, 64'hCAFE_F00D_1234_5678);
      a_p1_req = 0;
      tick();

      // Store on port 1.
      a_p1_req = 1; a_p1_we = 1; a_p1_addr = 10'h010; a_p1_word = 2'd2;
      a_p1_wdata = 64'hDEAD_BEEF;
      tick();
      check("st_en",    a_mem_en, 1);
      check("st_we",    a_mem_we, 1);
      check("st_addr",  a_mem_addr, 10'h010);
      check("st_wdata", a_mem_wdata, 64'hDEAD_BEEF);
      tick();
      check("st_en2",   {a_mem_en, a_mem_we}, 2'b00);
      tick();
      check("st_rdy",   a_p1_ready, 1);
      check("st_keep",  a_p1_rdata, 64'hCAFE_F00D_1234_5678);
      a_p1_req = 0; a_p1_we = 0;
      tick();

      // Contention: port 1 won last, so the order is 0,1,0,1.
      a_p0_req = 1; a_p0_addr = 10'h004;
      a_p1_req = 1; a_p1_addr = 10'h040;
      for (int k = 1; k <= 16; k++) begin
         tick();
         check($sformatf("cont_rdy_k%0d", k), {a_p1_ready, a_p0_ready},
               (k == 3 || k == 11) ? 2'b01 : (k == 7 || k == 15) ? 2'b10 : 2'b00);
         if (k == 3)  check("cont_p0_data", a_p0_rdata, 64'h1122_3344_5566_7788);
         if (k == 7)  check("cont_p1_data", a_p1_rdata, 64'h5A5A_0040_0000_0002);
         if (k == 15) begin
            a_p0_req = 0;
            a_p1_req = 0;
         end
      end
      check("cont_end_busy", a_busy, 0);

      // Asynchronous reset mid-cycle during ISSUE with request held.
      a_p0_req = 1; a_p0_addr = 10'h020; a_p0_word = 2'd1;
      tick();
      check("mr_pre_en", a_mem_en, 1);
      #2 rst = 1'b1;
      #1;
      check("mr_en",    a_mem_en, 0);
      check("mr_busy",  a_busy, 0);
      check("mr_rdy",   {a_p1_ready, a_p0_ready}, 0);
      check("mr_p0rd",  a_p0_rdata, 0);
      check("mr_p1rd",  a_p1_rdata, 0);
      check("mr_addr",  a_mem_addr, 0);
      check("mr_word",  a_mem_word, 0);
      check("mr_wdata", a_mem_wdata, 0);
      a_p0_req = 0;
      tick();
      rst = 1'b0;
      seen = 0;
      repeat (4) begin
         tick();
         seen += int'(a_p0_ready) + int'(a_mem_en);
      end
      check("mr_quiet", seen, 0);

      // LAT=3 load on port 1: ready at c+5.
      b_p1_req = 1; b_p1_addr = 10'h055; b_p1_word = 2'd3;
      for (int k = 1; k <= 6; k++) begin
         tick();
         if (k == 1) check("l3_en", b_mem_en, 1);
         check($sformatf("l3_rdy_k%0d", k), b_p1_ready, (k == 5) ? 1'b1 : 1'b0);
         if (k == 5) begin
            check("l3_data", b_p1_rdata, 64'h0123_4567_89AB_CDEF);
            b_p1_req = 0;
         end
      end

      // LAT=3 reset during WAIT.
      b_p0_req = 1; b_p0_addr = 10'h004;
      tick();
      tick();
      tick();
      check("rw_pre_busy", b_busy, 1);
      #2 rst = 1'b1;
      #1;
      check("rw_busy", b_busy, 0);
      check("rw_rdy",  {b_p1_ready, b_p0_ready}, 0);
      b_p0_req = 0;
      tick();
      rst = 1'b0;
      seen = 0;
      repeat (6) begin
         tick();
         seen += int'(b_p0_ready) + int'(b_p1_ready);
      end
      check("rw_no_ready", seen, 0);

      // Contended request after reset: port 0 first.
      b_p0_req = 1; b_p0_addr = 10'h030;
      b_p1_req = 1; b_p1_addr = 10'h040;
      tick();
      check("rw_grant0_addr", b_mem_addr, 10'h030);
      repeat (4) tick();
      check("rw_p0_rdy",  {b_p1_ready, b_p0_ready}, 2'b01);
      check("rw_p0_data", b_p0_rdata, 64'hA5A5_0030_0000_0001);
      b_p0_req = 0;
      repeat (6) tick();
      check("rw_p1_rdy",  {b_p1_ready, b_p0_ready}, 2'b10);
      check("rw_p1_data", b_p1_rdata, 64'h5A5A_0040_0000_0002);
      b_p1_req = 0;
      tick();
      check("rw_end_busy", b_busy, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
